// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared defaults and parameter legality check for pipe_adder
package pipe_adder_pkg;

   localparam int DEFAULT_W      = 32;
   localparam int DEFAULT_STAGES = 4;

   // True when the carry chain splits into STAGES equal, non-empty chunks.
   function automatic bit params_ok(input int w, input int stages);
      return (stages >= 1) && (stages <= w) && ((w % stages) == 0);
   endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// rtl/pipe_adder_if.sv - operand/result handshake bundle for pipe_adder
interface pipe_adder_if
   import pipe_adder_pkg::*;
#(
   parameter int W = DEFAULT_W
) ();

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;
   logic         cout;
   logic         ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, s, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, s, cout, ovf
   );

endinterface

// File: rtl/pipe_adder_stage.sv
// rtl/pipe_adder_stage.sv - one carry chunk: chunk adder, valid bit, operand skew and result deskew registers
module pipe_adder_stage
   import pipe_adder_pkg::*;
#(
   parameter int W  = DEFAULT_W,
   parameter int C  = DEFAULT_W / DEFAULT_STAGES,
   parameter int LO = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         adv_i,
   input  logic         valid_i,
   input  logic         carry_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] sum_i,
   output logic         valid_o,
   output logic         carry_o,
   output logic         ovf_o,
   output logic [W-1:0] a_o,
   output logic [W-1:0] b_o,
   output logic [W-1:0] sum_o
);

   // Deskew keeps only the result bits produced so far; skew keeps only operand bits still to be added.
   localparam int DS_W = LO + C;
   localparam int HI_W = W - DS_W;

   logic [C:0]      chunk;
   logic [DS_W-1:0] sum_d;
   logic [DS_W-1:0] sum_q;
   logic            valid_q;
   logic            carry_q;
   logic            ovf_d;
   logic            ovf_q;
   logic            unused_bits;

   always_comb begin
      chunk          = {1'b0, a_i[LO +: C]} + {1'b0, b_i[LO +: C]} + {{C{1'b0}}, carry_i};
      sum_d          = sum_i[DS_W-1:0];
      sum_d[LO +: C] = chunk[C-1:0];
      // Carry into the chunk MSB recovered from its sum bit, then compared with the carry out.
      ovf_d          = a_i[LO+C-1] ^ b_i[LO+C-1] ^ chunk[C-1] ^ chunk[C];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         sum_q   <= '0;
      end else if (adv_i) begin
         valid_q <= valid_i;
         carry_q <= chunk[C];
         ovf_q   <= ovf_d;
         sum_q   <= sum_d;
      end
   end

   if (HI_W > 0) begin : g_skew
      logic [HI_W-1:0] a_q;
      logic [HI_W-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
         end else if (adv_i) begin
            a_q <= a_i[W-1 -: HI_W];
            b_q <= b_i[W-1 -: HI_W];
         end
      end

      assign a_o = {a_q, {DS_W{1'b0}}};
      assign b_o = {b_q, {DS_W{1'b0}}};
   end else begin : g_no_skew
      assign a_o = '0;
      assign b_o = '0;
   end

   assign valid_o     = valid_q;
   assign carry_o     = carry_q;
   assign ovf_o       = ovf_q;
   assign sum_o       = W'(sum_q);
   assign unused_bits = ^{a_i, b_i, sum_i};

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined W-bit add/subtract with global-stall valid/ready handshake
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int W      = DEFAULT_W,
   parameter int STAGES = DEFAULT_STAGES
) (
   input  logic        clk,
   input  logic        rst_n,
   pipe_adder_if.slave bus
);

   localparam int C = W / STAGES;

   if (!params_ok(W, STAGES)) begin : g_param_check
      $error("pipe_adder: W must be a multiple of STAGES with 1 <= STAGES <= W");
   end

   logic         adv;
   logic         valid_c [0:STAGES];
   logic         carry_c [0:STAGES];
   logic [W-1:0] a_c     [0:STAGES];
   logic [W-1:0] b_c     [0:STAGES];
   logic [W-1:0] sum_c   [0:STAGES];
   logic         ovf_last;
   logic         unused_tail;

   // The whole pipeline advances together unless a finished result is being held.
   assign adv = !valid_c[STAGES] || bus.out_ready;

   // Subtraction is a + ~b + 1, so cin is replaced by the forced carry.
   assign valid_c[0] = bus.in_valid;
   assign carry_c[0] = bus.sub | bus.cin;
   assign a_c[0]     = bus.a;
   assign b_c[0]     = bus.b ^ {W{bus.sub}};
   assign sum_c[0]   = '0;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic ovf_k;

      pipe_adder_stage #(
         .W  (W),
         .C  (C),
         .LO (k * C)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .adv_i   (adv),
         .valid_i (valid_c[k]),
         .carry_i (carry_c[k]),
         .a_i     (a_c[k]),
         .b_i     (b_c[k]),
         .sum_i   (sum_c[k]),
         .valid_o (valid_c[k+1]),
         .carry_o (carry_c[k+1]),
         .ovf_o   (ovf_k),
         .a_o     (a_c[k+1]),
         .b_o     (b_c[k+1]),
         .sum_o   (sum_c[k+1])
      );

      if (k == STAGES - 1) begin : g_last
         assign ovf_last = ovf_k;
      end else begin : g_mid
         logic unused_ovf;
         assign unused_ovf = ovf_k;
      end
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = valid_c[STAGES];
   assign bus.s         = sum_c[STAGES];
   assign bus.cout      = carry_c[STAGES];
   assign bus.ovf       = ovf_last;
   assign unused_tail   = ^{a_c[STAGES], b_c[STAGES]};

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - directed and backpressure bench for pipe_adder plus a width/depth sweep
module tb_pipe_adder;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pipe_adder_if #(.W(32)) bus ();
   pipe_adder #(.W(32), .STAGES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   logic [63:0] sw_a, sw_b;
   logic        sw_cin, sw_sub, sw_valid;

   pipe_adder_if #(.W(8))  if_w8  ();
   pipe_adder_if #(.W(16)) if_w16 ();
   pipe_adder_if #(.W(64)) if_w64 ();
   pipe_adder_if #(.W(32)) if_w32 ();

   pipe_adder #(.W(8),  .STAGES(1))  dut_w8  (.clk(clk), .rst_n(rst_n), .bus(if_w8));
   pipe_adder #(.W(16), .STAGES(2))  dut_w16 (.clk(clk), .rst_n(rst_n), .bus(if_w16));
   pipe_adder #(.W(64), .STAGES(8))  dut_w64 (.clk(clk), .rst_n(rst_n), .bus(if_w64));
   pipe_adder #(.W(32), .STAGES(32)) dut_w32 (.clk(clk), .rst_n(rst_n), .bus(if_w32));

   assign if_w8.in_valid  = sw_valid;  assign if_w8.a  = sw_a[7:0];  assign if_w8.b  = sw_b[7:0];
   assign if_w16.in_valid = sw_valid;  assign if_w16.a = sw_a[15:0]; assign if_w16.b = sw_b[15:0];
   assign if_w64.in_valid = sw_valid;  assign if_w64.a = sw_a;       assign if_w64.b = sw_b;
   assign if_w32.in_valid = sw_valid;  assign if_w32.a = sw_a[31:0]; assign if_w32.b = sw_b[31:0];
   assign if_w8.cin  = sw_cin; assign if_w16.cin = sw_cin; assign if_w64.cin = sw_cin; assign if_w32.cin = sw_cin;
   assign if_w8.sub  = sw_sub; assign if_w16.sub = sw_sub; assign if_w64.sub = sw_sub; assign if_w32.sub = sw_sub;
   assign if_w8.out_ready = 1'b1; assign if_w16.out_ready = 1'b1;
   assign if_w64.out_ready = 1'b1; assign if_w32.out_ready = 1'b1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [31:0] s;
      logic        cout;
      logic        ovf;
      int          cyc;
   } obs_t;

   obs_t obs_q [$];
   int   acc_q [$];

   logic [31:0] prev_s     = '0;
   logic        prev_c     = 1'b0;
   logic        prev_o     = 1'b0;
   logic        prev_stall = 1'b0;
   int          stall_viol = 0;

   int          sw_cnt [4] = '{0, 0, 0, 0};
   logic [63:0] sw_s   [4];
   logic        sw_c   [4];
   logic        sw_o   [4];
   int          sw_w   [4] = '{8, 16, 64, 32};

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready)
         obs_q.push_back('{s: bus.s, cout: bus.cout, ovf: bus.ovf, cyc: cyc});
      if (rst_n && bus.in_valid && bus.in_ready)
         acc_q.push_back(cyc);
      if (rst_n && prev_stall && ({bus.s, bus.cout, bus.ovf} !== {prev_s, prev_c, prev_o}))
         stall_viol <= stall_viol + 1;
      if (rst_n && bus.out_valid && !bus.out_ready && bus.in_ready)
         stall_viol <= stall_viol + 1;
      prev_stall <= rst_n && bus.out_valid && !bus.out_ready;
      prev_s     <= bus.s;
      prev_c     <= bus.cout;
      prev_o     <= bus.ovf;
   end

   always @(negedge clk) begin
      if (if_w8.out_valid)  begin sw_cnt[0] <= sw_cnt[0] + 1; sw_s[0] <= 64'(if_w8.s);  sw_c[0] <= if_w8.cout;  sw_o[0] <= if_w8.ovf;  end
      if (if_w16.out_valid) begin sw_cnt[1] <= sw_cnt[1] + 1; sw_s[1] <= 64'(if_w16.s); sw_c[1] <= if_w16.cout; sw_o[1] <= if_w16.ovf; end
      if (if_w64.out_valid) begin sw_cnt[2] <= sw_cnt[2] + 1; sw_s[2] <= if_w64.s;      sw_c[2] <= if_w64.cout; sw_o[2] <= if_w64.ovf; end
      if (if_w32.out_valid) begin sw_cnt[3] <= sw_cnt[3] + 1; sw_s[3] <= 64'(if_w32.s); sw_c[3] <= if_w32.cout; sw_o[3] <= if_w32.ovf; end
   end

   // Reference result {ovf, cout, s} for a w-bit operation, using the sign-rule for overflow.
   function automatic logic [65:0] modelw(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
      logic [63:0] m, aa, bb, s;
      logic [64:0] full;
      logic        co, ov;
      m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      aa   = a & m;
      bb   = (sub ? ~b : b) & m;
      full = {1'b0, aa} + {1'b0, bb} + 65'(sub | cin);
      s    = full[63:0] & m;
      co   = full[w];
      ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
      return {ov, co, s};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      bus.sub      = sub;
      tick(1);
   endtask

   task automatic wait_obs(input int n);
      int t = 0;
      while (obs_q.size() < n && t < 3000) begin
         tick(1);
         t++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
      total++; if (bus.s !== 32'h0)        begin bad++; $display("FAIL reset_s got=%h want=00000000", bus.s); end
      total++; if (bus.cout !== 1'b0)      begin bad++; $display("FAIL reset_cout got=%b want=0", bus.cout); end
      total++; if (bus.ovf !== 1'b0)       begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.ovf); end
      total++; if (bus.in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
      tick(2);
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL idle_out_valid got=%b want=0", bus.out_valid); end
   endtask

   task automatic test_carry();
      obs_t o;
      obs_q.delete();
      send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
      send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      wait_obs(2);
      total++;
      if (obs_q.size() != 2) begin
         bad++; $display("FAIL carry_count got=%0d want=2", obs_q.size());
      end else begin
         o = obs_q.pop_front();
         total++; if ({o.s, o.cout, o.ovf} !== {32'h0000_0000, 1'b1, 1'b0})
            begin bad++; $display("FAIL carry_wrap got=%h/%b/%b want=00000000/1/0", o.s, o.cout, o.ovf); end
         o = obs_q.pop_front();
         total++; if ({o.s, o.cout, o.ovf} !== {32'h8000_0000, 1'b0, 1'b1})
            begin bad++; $display("FAIL carry_ovf got=%h/%b/%b want=80000000/0/1", o.s, o.cout, o.ovf); end
      end
   endtask

   task automatic test_subtract();
      obs_t o;
      obs_q.delete();
      send(32'h5, 32'h7, 1'b1, 1'b1);
      send(32'h8000_0000, 32'h1, 1'b0, 1'b1);
      bus.in_valid = 1'b0;
      bus.sub      = 1'b0;
      wait_obs(2);
      total++;
      if (obs_q.size() != 2) begin
         bad++; $display("FAIL sub_count got=%0d want=2", obs_q.size());
      end else begin
         o = obs_q.pop_front();
         total++; if ({o.s, o.cout, o.ovf} !== {32'hFFFF_FFFE, 1'b0, 1'b0})
            begin bad++; $display("FAIL sub_borrow got=%h/%b/%b want=fffffffe/0/0", o.s, o.cout, o.ovf); end
         o = obs_q.pop_front();
         total++; if ({o.s, o.cout, o.ovf} !== {32'h7FFF_FFFF, 1'b1, 1'b1})
            begin bad++; $display("FAIL sub_ovf got=%h/%b/%b want=7fffffff/1/1", o.s, o.cout, o.ovf); end
      end
   endtask

   task automatic test_stream();
      obs_t o;
      int   ac;
      int   last;
      obs_q.delete();
      acc_q.delete();
      for (int k = 0; k < 100; k++) send(32'(k * 10000), 32'(k * 10000), 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      wait_obs(100);
      total++; if (obs_q.size() != 100 || acc_q.size() != 100)
         begin bad++; $display("FAIL stream_count got=%0d/%0d want=100/100", obs_q.size(), acc_q.size()); end
      last = 0;
      for (int k = 0; k < 100; k++) begin
         if (obs_q.size() == 0 || acc_q.size() == 0) break;
         o  = obs_q.pop_front();
         ac = acc_q.pop_front();
         total++; if (o.s !== 32'(k * 20000))
            begin bad++; $display("FAIL stream_sum k=%0d got=%0d want=%0d", k, o.s, k * 20000); end
         total++; if (o.cyc - ac != 4)
            begin bad++; $display("FAIL stream_latency k=%0d got=%0d want=4", k, o.cyc - ac); end
         if (k > 0) begin
            total++; if (o.cyc - last != 1)
               begin bad++; $display("FAIL back_to_back k=%0d gap=%0d want=1", k, o.cyc - last); end
         end
         last = o.cyc;
      end
   endtask

   task automatic test_midreset();
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) send(32'(k + 1), 32'(100), 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL midreset_full got=%b want=1", bus.out_valid); end
      rst_n = 1'b0;
      #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midreset_flush got=%b want=0", bus.out_valid); end
      total++; if (bus.s !== 32'h0)        begin bad++; $display("FAIL midreset_s got=%h want=00000000", bus.s); end
      obs_q.delete();
      tick(2);
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      tick(10);
      total++; if (obs_q.size() != 0) begin bad++; $display("FAIL midreset_stale got=%0d want=0", obs_q.size()); end
   endtask

   task automatic test_backpressure();
      logic [65:0] exp_q [$];
      logic [65:0] e;
      obs_t        o;
      int          viol0;
      int          timeouts;
      bit          done;
      obs_q.delete();
      viol0    = stall_viol;
      timeouts = 0;
      done     = 1'b0;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               int guard = 0;
               bus.a   = $urandom;
               bus.b   = $urandom;
               bus.cin = 1'($urandom_range(0, 1));
               bus.sub = 1'($urandom_range(0, 1));
               exp_q.push_back(modelw(32, 64'(bus.a), 64'(bus.b), bus.cin, bus.sub));
               bus.in_valid = 1'b1;
               @(negedge clk);
               while (!bus.in_ready && guard < 1000) begin @(negedge clk); guard++; end
               if (guard >= 1000) timeouts++;
               tick(1);
            end
            bus.in_valid = 1'b0;
            done = 1'b1;
         end
         begin
            while (!done) begin
               bus.out_ready = 1'($urandom_range(0, 1));
               tick(1);
            end
            bus.out_ready = 1'b1;
         end
      join
      wait_obs(1000);
      total++; if (timeouts != 0) begin bad++; $display("FAIL bp_accept_timeout got=%0d want=0", timeouts); end
      total++; if (obs_q.size() != 1000) begin bad++; $display("FAIL bp_count got=%0d want=1000", obs_q.size()); end
      for (int i = 0; i < 1000; i++) begin
         if (obs_q.size() == 0) break;
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         total++; if ({o.ovf, o.cout, 32'h0, o.s} !== e)
            begin bad++; $display("FAIL bp_result i=%0d got=%h/%b/%b want=%h/%b/%b", i, o.s, o.cout, o.ovf, e[31:0], e[64], e[65]); end
      end
      total++; if (stall_viol - viol0 != 0) begin bad++; $display("FAIL bp_stall_stable got=%0d want=0", stall_viol - viol0); end
   endtask

   task automatic test_sweep();
      logic [63:0] va [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_7FFF_7FFF_7FFF, 64'h5,
                             64'h8000_0000_8000_8080, 64'h0123_4567_89AB_CDEF, 64'hF0F0_0F0F_AAAA_5555};
      logic [63:0] vb [6] = '{64'h1, 64'h1, 64'h7, 64'h1, 64'hFEDC_BA98_7654_3210, 64'h0F0F_F0F0_5555_AAAA};
      logic        vc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic        vs [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      int          cnt0 [4];
      logic [65:0] e;
      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < 4; i++) cnt0[i] = sw_cnt[i];
         sw_a = va[v]; sw_b = vb[v]; sw_cin = vc[v]; sw_sub = vs[v];
         sw_valid = 1'b1;
         tick(1);
         sw_valid = 1'b0;
         tick(40);
         for (int i = 0; i < 4; i++) begin
            e = modelw(sw_w[i], va[v], vb[v], vc[v], vs[v]);
            total++;
            if (sw_cnt[i] - cnt0[i] != 1 || {sw_o[i], sw_c[i], sw_s[i]} !== e)
               begin bad++; $display("FAIL sweep w=%0d v=%0d got=%0d:%h/%b/%b want=1:%h/%b/%b", sw_w[i], v,
                  sw_cnt[i] - cnt0[i], sw_s[i], sw_c[i], sw_o[i], e[63:0], e[64], e[65]); end
         end
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b1;
      sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0; sw_valid = 1'b0;
      #1;
      test_reset();
      test_carry();
      test_subtract();
      test_stream();
      test_midreset();
      test_backpressure();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
